// File: rtl/i2c_slave.sv
// rtl/i2c_slave.sv - I2C target endpoint with fixed 7-bit address, byte RX/TX to fabric
// Open-drain SDA (drives 0 or Z only); never stretches SCL.
`timescale 1ns/1ps
module i2c_slave #(
  parameter logic [6:0] SLAVE_ADDR = 7'h42
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       scl,
  inout  wire        sda,
  input  logic [7:0] tx_data,
  input  logic       rx_ack_en,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       tx_req,
  output logic       nack_rx,
  output logic       busy
);

  typedef enum logic [3:0] {
    S_IDLE,
    S_ADDR,
    S_ADDR_ACK,
    S_RX_BYTE,
    S_RX_ACK,
    S_RX_NACK,
    S_TX_BYTE,
    S_TX_ACK,
    S_WAIT_STOP
  } state_t;

  logic       r_scl_s1, r_scl_s2, r_scl_d;
  logic       r_sda_s1, r_sda_s2, r_sda_d;

  state_t     r_state, w_state_nxt;
  logic [7:0] r_shift, w_shift_nxt;
  logic [2:0] r_bit_cnt, w_bit_cnt_nxt;
  logic       r_rw, w_rw_nxt;
  logic       r_phase, w_phase_nxt;
  logic       r_sda_low, w_sda_low_nxt;
  logic       r_sda_oe, w_sda_oe_nxt;
  logic [7:0] r_rx_data, w_rx_data_nxt;
  logic       r_rx_valid, w_rx_valid_nxt;
  logic       r_tx_req, w_tx_req_nxt;
  logic       r_nack_rx, w_nack_rx_nxt;
  logic       r_busy, w_busy_nxt;

  logic       w_scl_rise, w_scl_fall, w_start, w_stop;
  logic [7:0] w_rx_byte;

  // Synchronizers reset high so releasing reset cannot look like a bus edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_scl_s1 <= 1'b1;
      r_scl_s2 <= 1'b1;
      r_scl_d  <= 1'b1;
      r_sda_s1 <= 1'b1;
      r_sda_s2 <= 1'b1;
      r_sda_d  <= 1'b1;
    end else begin
      r_scl_s1 <= scl;
      r_scl_s2 <= r_scl_s1;
      r_scl_d  <= r_scl_s2;
      r_sda_s1 <= sda;
      r_sda_s2 <= r_sda_s1;
      r_sda_d  <= r_sda_s2;
    end
  end

  assign w_scl_rise = r_scl_s2 & ~r_scl_d;
  assign w_scl_fall = ~r_scl_s2 & r_scl_d;
  // SCL must be steadily high across the SDA edge; a coincident SCL change is a data change.
  assign w_start    = r_sda_d & ~r_sda_s2 & r_scl_s2 & r_scl_d;
  assign w_stop     = ~r_sda_d & r_sda_s2 & r_scl_s2 & r_scl_d;
  assign w_rx_byte  = {r_shift[6:0], r_sda_s2};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_shift    <= 8'h00;
      r_bit_cnt  <= 3'd0;
      r_rw       <= 1'b0;
      r_phase    <= 1'b0;
      r_sda_low  <= 1'b0;
      r_sda_oe   <= 1'b0;
      r_rx_data  <= 8'h00;
      r_rx_valid <= 1'b0;
      r_tx_req   <= 1'b0;
      r_nack_rx  <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_shift    <= w_shift_nxt;
      r_bit_cnt  <= w_bit_cnt_nxt;
      r_rw       <= w_rw_nxt;
      r_phase    <= w_phase_nxt;
      r_sda_low  <= w_sda_low_nxt;
      r_sda_oe   <= w_sda_oe_nxt;
      r_rx_data  <= w_rx_data_nxt;
      r_rx_valid <= w_rx_valid_nxt;
      r_tx_req   <= w_tx_req_nxt;
      r_nack_rx  <= w_nack_rx_nxt;
      r_busy     <= w_busy_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_shift_nxt    = r_shift;
    w_bit_cnt_nxt  = r_bit_cnt;
    w_rw_nxt       = r_rw;
    w_phase_nxt    = r_phase;
    w_sda_low_nxt  = r_sda_low;
    w_sda_oe_nxt   = r_sda_low;
    w_rx_data_nxt  = r_rx_data;
    w_rx_valid_nxt = 1'b0;
    w_tx_req_nxt   = 1'b0;
    w_nack_rx_nxt  = 1'b0;
    w_busy_nxt     = r_busy;

    // tx_data is captured while tx_req is high, and bit 7 goes straight to the pin.
    if (r_tx_req && r_state == S_TX_BYTE) begin
      w_shift_nxt   = tx_data;
      w_sda_low_nxt = ~tx_data[7];
      w_sda_oe_nxt  = ~tx_data[7];
    end

    if (w_stop) begin
      w_state_nxt   = S_IDLE;
      w_sda_low_nxt = 1'b0;
      w_sda_oe_nxt  = 1'b0;
      w_phase_nxt   = 1'b0;
      w_busy_nxt    = 1'b0;
    end else if (w_start) begin
      w_state_nxt   = S_ADDR;
      w_bit_cnt_nxt = 3'd0;
      w_sda_low_nxt = 1'b0;
      w_sda_oe_nxt  = 1'b0;
      w_phase_nxt   = 1'b0;
      w_busy_nxt    = 1'b0;
    end else begin
      case (r_state)
        S_ADDR: begin
          if (w_scl_rise) begin
            w_shift_nxt   = w_rx_byte;
            w_bit_cnt_nxt = r_bit_cnt + 3'd1;
            if (r_bit_cnt == 3'd7) begin
              if (w_rx_byte[7:1] == SLAVE_ADDR) begin
                w_rw_nxt    = w_rx_byte[0];
                w_phase_nxt = 1'b0;
                w_busy_nxt  = 1'b1;
                w_state_nxt = S_ADDR_ACK;
              end else begin
                w_busy_nxt  = 1'b0;
                w_state_nxt = S_WAIT_STOP;
              end
            end
          end
        end
        S_ADDR_ACK: begin
          if (w_scl_fall) begin
            if (!r_phase) begin
              w_sda_low_nxt = 1'b1;
              w_phase_nxt   = 1'b1;
            end else begin
              w_phase_nxt   = 1'b0;
              w_bit_cnt_nxt = 3'd0;
              w_sda_low_nxt = 1'b0;
              if (r_rw) begin
                w_tx_req_nxt = 1'b1;
                w_state_nxt  = S_TX_BYTE;
              end else begin
                w_state_nxt  = S_RX_BYTE;
              end
            end
          end
        end
        S_RX_BYTE: begin
          if (w_scl_rise) begin
            w_shift_nxt   = w_rx_byte;
            w_bit_cnt_nxt = r_bit_cnt + 3'd1;
            w_phase_nxt   = 1'b0;
            if (r_bit_cnt == 3'd7) begin
              if (rx_ack_en) begin
                w_rx_data_nxt  = w_rx_byte;
                w_rx_valid_nxt = 1'b1;
                w_state_nxt    = S_RX_ACK;
              end else begin
                w_state_nxt    = S_RX_NACK;
              end
            end
          end
        end
        S_RX_ACK: begin
          if (w_scl_fall) begin
            if (!r_phase) begin
              w_sda_low_nxt = 1'b1;
              w_phase_nxt   = 1'b1;
            end else begin
              w_sda_low_nxt = 1'b0;
              w_phase_nxt   = 1'b0;
              w_state_nxt   = S_RX_BYTE;
            end
          end
        end
        S_RX_NACK: begin
          if (w_scl_fall) begin
            if (!r_phase) begin
              w_phase_nxt = 1'b1;
            end else begin
              w_phase_nxt = 1'b0;
              w_busy_nxt  = 1'b0;
              w_state_nxt = S_WAIT_STOP;
            end
          end
        end
        S_TX_BYTE: begin
          if (w_scl_fall) begin
            if (r_bit_cnt == 3'd7) begin
              w_sda_low_nxt = 1'b0;
              w_bit_cnt_nxt = 3'd0;
              w_phase_nxt   = 1'b0;
              w_state_nxt   = S_TX_ACK;
            end else begin
              w_shift_nxt   = {r_shift[6:0], 1'b0};
              w_sda_low_nxt = ~r_shift[6];
              w_bit_cnt_nxt = r_bit_cnt + 3'd1;
            end
          end
        end
        S_TX_ACK: begin
          if (w_scl_rise) begin
            if (!r_sda_s2) begin
              w_phase_nxt = 1'b1;
            end else begin
              w_nack_rx_nxt = 1'b1;
              w_busy_nxt    = 1'b0;
              w_state_nxt   = S_WAIT_STOP;
            end
          end else if (w_scl_fall && r_phase) begin
            w_phase_nxt   = 1'b0;
            w_bit_cnt_nxt = 3'd0;
            w_tx_req_nxt  = 1'b1;
            w_state_nxt   = S_TX_BYTE;
          end
        end
        S_WAIT_STOP: begin
          w_sda_low_nxt = 1'b0;
          w_busy_nxt    = 1'b0;
        end
        default: begin
          w_state_nxt = S_IDLE;
        end
      endcase
    end
  end

  assign sda      = r_sda_oe ? 1'b0 : 1'bz;
  assign rx_data  = r_rx_data;
  assign rx_valid = r_rx_valid;
  assign tx_req   = r_tx_req;
  assign nack_rx  = r_nack_rx;
  assign busy     = r_busy;

endmodule

// File: tb/tb_i2c_slave.sv
// tb/tb_i2c_slave.sv - directed bench for i2c_slave acting as the bus master
`timescale 1ns/1ps
module tb_i2c_slave;

  localparam int Q = 8;

  logic       clk;
  logic       rst;
  logic       m_scl;
  logic       m_sda;
  logic [7:0] tx_data;
  logic       rx_ack_en;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       tx_req;
  logic       nack_rx;
  logic       busy;
  wire        sda;

  int n_vec = 0;
  int n_fail = 0;
  int rxv_cnt = 0;
  int txr_cnt = 0;
  int nack_cnt = 0;
  int drive_cnt = 0;
  int busy_cnt = 0;

  assign sda = m_sda ? 1'bz : 1'b0;
  pullup (sda);

  i2c_slave #(.SLAVE_ADDR(7'h42)) dut (
    .clk       (clk),
    .rst       (rst),
    .scl       (m_scl),
    .sda       (sda),
    .tx_data   (tx_data),
    .rx_ack_en (rx_ack_en),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .tx_req    (tx_req),
    .nack_rx   (nack_rx),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rx_valid) rxv_cnt++;
    if (tx_req) txr_cnt++;
    if (nack_rx) nack_cnt++;
    if (busy) busy_cnt++;
    if (m_sda && sda === 1'b0) drive_cnt++;
  end

  task automatic wq(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic bus_start;
    m_sda = 1'b1; wq(Q);
    m_scl = 1'b1; wq(Q);
    m_sda = 1'b0; wq(Q);
    m_scl = 1'b0; wq(Q);
  endtask

  task automatic bus_stop;
    m_sda = 1'b0; wq(Q);
    m_scl = 1'b1; wq(Q);
    m_sda = 1'b1; wq(Q);
  endtask

  task automatic write_bit(input logic b);
    m_sda = b;    wq(Q);
    m_scl = 1'b1; wq(2 * Q);
    m_scl = 1'b0; wq(Q);
  endtask

  task automatic read_bit(output logic b);
    m_sda = 1'b1; wq(Q);
    m_scl = 1'b1; wq(Q);
    b = sda;      wq(Q);
    m_scl = 1'b0; wq(Q);
  endtask

  task automatic write_byte(input logic [7:0] d, output logic acked);
    logic b;
    for (int i = 7; i >= 0; i--) write_bit(d[i]);
    read_bit(b);
    acked = ~b;
  endtask

  task automatic read_byte(output logic [7:0] d, input logic master_ack);
    logic b;
    for (int i = 7; i >= 0; i--) begin
      read_bit(b);
      d[i] = b;
    end
    write_bit(~master_ack);
  endtask

  task automatic test_reset;
    rst = 1'b1; m_scl = 1'b1; m_sda = 1'b1; rx_ack_en = 1'b1; tx_data = 8'h00;
    wq(4);
    n_vec++; if (sda !== 1'b1) begin n_fail++; $display("FAIL reset_sda: got %b expected 1", sda); end
    n_vec++; if (rx_data !== 8'h00) begin n_fail++; $display("FAIL reset_rx_data: got %h expected 00", rx_data); end
    n_vec++; if (rx_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rx_valid: got %b expected 0", rx_valid); end
    n_vec++; if (tx_req !== 1'b0) begin n_fail++; $display("FAIL reset_tx_req: got %b expected 0", tx_req); end
    n_vec++; if (nack_rx !== 1'b0) begin n_fail++; $display("FAIL reset_nack_rx: got %b expected 0", nack_rx); end
    n_vec++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
    rst = 1'b0;
    wq(4);
  endtask

  task automatic test_write;
    logic [7:0] a;
    logic       ack;
    int         rxv0;
    a = 8'h84;
    rxv0 = rxv_cnt;
    bus_start;
    for (int i = 7; i >= 1; i--) write_bit(a[i]);
    m_sda = a[0]; wq(Q);
    m_scl = 1'b1; wq(2 * Q);
    // Release SDA on the same edge SCL falls: must not read as STOP.
    m_scl = 1'b0; m_sda = 1'b1;
    wq(3);
    n_vec++; if (sda !== 1'b1) begin n_fail++; $display("FAIL ack_lat3: got %b expected 1", sda); end
    wq(1);
    n_vec++; if (sda !== 1'b0) begin n_fail++; $display("FAIL ack_lat4: got %b expected 0", sda); end
    wq(Q - 4);
    m_scl = 1'b1; wq(Q);
    n_vec++; if (sda !== 1'b0) begin n_fail++; $display("FAIL wr_addr_ack: got %b expected 0", sda); end
    n_vec++; if (busy !== 1'b1) begin n_fail++; $display("FAIL wr_busy_ack: got %b expected 1", busy); end
    wq(Q);
    m_scl = 1'b0; wq(Q);
    write_byte(8'hA5, ack);
    n_vec++; if (ack !== 1'b1) begin n_fail++; $display("FAIL wr_data_ack: got %b expected 1", ack); end
    n_vec++; if (rx_data !== 8'hA5) begin n_fail++; $display("FAIL wr_rx_data: got %h expected a5", rx_data); end
    n_vec++; if (rxv_cnt - rxv0 !== 1) begin n_fail++; $display("FAIL wr_rx_valid_cnt: got %0d expected 1", rxv_cnt - rxv0); end
    n_vec++; if (busy !== 1'b1) begin n_fail++; $display("FAIL wr_busy_data: got %b expected 1", busy); end
    bus_stop;
    n_vec++; if (busy !== 1'b0) begin n_fail++; $display("FAIL wr_busy_stop: got %b expected 0", busy); end
  endtask

  task automatic test_mismatch;
    logic ack;
    int   rxv0, drv0, busy0;
    rxv0 = rxv_cnt; drv0 = drive_cnt; busy0 = busy_cnt;
    bus_start;
    write_byte(8'h86, ack);
    n_vec++; if (ack !== 1'b0) begin n_fail++; $display("FAIL mm_addr_ack: got %b expected 0", ack); end
    write_byte(8'h11, ack);
    n_vec++; if (ack !== 1'b0) begin n_fail++; $display("FAIL mm_data_ack: got %b expected 0", ack); end
    bus_stop;
    n_vec++; if (drive_cnt - drv0 !== 0) begin n_fail++; $display("FAIL mm_sda_driven: got %0d expected 0", drive_cnt - drv0); end
    n_vec++; if (rxv_cnt - rxv0 !== 0) begin n_fail++; $display("FAIL mm_rx_valid: got %0d expected 0", rxv_cnt - rxv0); end
    n_vec++; if (busy_cnt - busy0 !== 0) begin n_fail++; $display("FAIL mm_busy: got %0d expected 0", busy_cnt - busy0); end
    n_vec++; if (rx_data !== 8'hA5) begin n_fail++; $display("FAIL mm_rx_data: got %h expected a5", rx_data); end
  endtask

  task automatic test_read;
    logic       ack;
    logic [7:0] d;
    int         txr0, nack0;
    txr0 = txr_cnt; nack0 = nack_cnt;
    tx_data = 8'h3C;
    bus_start;
    write_byte(8'h85, ack);
    n_vec++; if (ack !== 1'b1) begin n_fail++; $display("FAIL rd_addr_ack: got %b expected 1", ack); end
    n_vec++; if (txr_cnt - txr0 !== 1) begin n_fail++; $display("FAIL rd_tx_req_1: got %0d expected 1", txr_cnt - txr0); end
    tx_data = 8'hF0;
    read_byte(d, 1'b1);
    n_vec++; if (d !== 8'h3C) begin n_fail++; $display("FAIL rd_byte0: got %h expected 3c", d); end
    n_vec++; if (txr_cnt - txr0 !== 2) begin n_fail++; $display("FAIL rd_tx_req_2: got %0d expected 2", txr_cnt - txr0); end
    read_byte(d, 1'b0);
    n_vec++; if (d !== 8'hF0) begin n_fail++; $display("FAIL rd_byte1: got %h expected f0", d); end
    n_vec++; if (nack_cnt - nack0 !== 1) begin n_fail++; $display("FAIL rd_nack_rx: got %0d expected 1", nack_cnt - nack0); end
    n_vec++; if (sda !== 1'b1) begin n_fail++; $display("FAIL rd_sda_released: got %b expected 1", sda); end
    n_vec++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rd_busy_after_nack: got %b expected 0", busy); end
    bus_stop;
    n_vec++; if (txr_cnt - txr0 !== 2) begin n_fail++; $display("FAIL rd_tx_req_total: got %0d expected 2", txr_cnt - txr0); end
  endtask

  task automatic test_not_ready;
    logic ack;
    int   rxv0;
    rxv0 = rxv_cnt;
    rx_ack_en = 1'b0;
    bus_start;
    write_byte(8'h84, ack);
    n_vec++; if (ack !== 1'b1) begin n_fail++; $display("FAIL nr_addr_ack: got %b expected 1", ack); end
    write_byte(8'h55, ack);
    n_vec++; if (ack !== 1'b0) begin n_fail++; $display("FAIL nr_data_nack: got %b expected 0", ack); end
    n_vec++; if (rx_data !== 8'hA5) begin n_fail++; $display("FAIL nr_rx_data: got %h expected a5", rx_data); end
    rx_ack_en = 1'b1;
    write_byte(8'h77, ack);
    n_vec++; if (ack !== 1'b0) begin n_fail++; $display("FAIL nr_ignored_ack: got %b expected 0", ack); end
    n_vec++; if (rxv_cnt - rxv0 !== 0) begin n_fail++; $display("FAIL nr_rx_valid: got %0d expected 0", rxv_cnt - rxv0); end
    n_vec++; if (busy !== 1'b0) begin n_fail++; $display("FAIL nr_busy: got %b expected 0", busy); end
    bus_stop;
  endtask

  task automatic test_repeated_start;
    logic       ack;
    logic [7:0] d;
    int         txr0;
    bus_start;
    write_byte(8'h84, ack);
    write_byte(8'h12, ack);
    n_vec++; if (rx_data !== 8'h12) begin n_fail++; $display("FAIL rs_rx_data: got %h expected 12", rx_data); end
    tx_data = 8'h9A;
    txr0 = txr_cnt;
    bus_start;
    write_byte(8'h85, ack);
    n_vec++; if (ack !== 1'b1) begin n_fail++; $display("FAIL rs_read_ack: got %b expected 1", ack); end
    n_vec++; if (txr_cnt - txr0 !== 1) begin n_fail++; $display("FAIL rs_tx_req: got %0d expected 1", txr_cnt - txr0); end
    read_byte(d, 1'b0);
    n_vec++; if (d !== 8'h9A) begin n_fail++; $display("FAIL rs_read_byte: got %h expected 9a", d); end
    bus_stop;
  endtask

  task automatic test_reset_mid;
    logic       ack;
    logic       b;
    tx_data = 8'hE7;
    bus_start;
    write_byte(8'h85, ack);
    for (int i = 0; i < 3; i++) read_bit(b);
    m_sda = 1'b1; wq(Q);
    n_vec++; if (sda !== 1'b0) begin n_fail++; $display("FAIL mid_bit4_driven: got %b expected 0", sda); end
    rst = 1'b1;
    #1;
    n_vec++; if (sda !== 1'b1) begin n_fail++; $display("FAIL mid_async_release: got %b expected 1", sda); end
    n_vec++; if (busy !== 1'b0) begin n_fail++; $display("FAIL mid_busy: got %b expected 0", busy); end
    n_vec++; if (rx_data !== 8'h00) begin n_fail++; $display("FAIL mid_rx_data: got %h expected 00", rx_data); end
    n_vec++; if ({rx_valid, tx_req, nack_rx} !== 3'b000) begin n_fail++; $display("FAIL mid_pulses: got %b expected 000", {rx_valid, tx_req, nack_rx}); end
    wq(2);
    rst = 1'b0;
    wq(2);
    bus_stop;
    bus_start;
    write_byte(8'h84, ack);
    n_vec++; if (ack !== 1'b1) begin n_fail++; $display("FAIL mid_after_addr_ack: got %b expected 1", ack); end
    write_byte(8'h3C, ack);
    n_vec++; if (ack !== 1'b1) begin n_fail++; $display("FAIL mid_after_data_ack: got %b expected 1", ack); end
    n_vec++; if (rx_data !== 8'h3C) begin n_fail++; $display("FAIL mid_after_rx_data: got %h expected 3c", rx_data); end
    bus_stop;
  endtask

  initial begin
    test_reset;
    test_write;
    test_mismatch;
    test_read;
    test_not_ready;
    test_repeated_start;
    test_reset_mid;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
